// File: rtl/ibex_boot_loader_if.sv
// Byte-stream input and RAM write port of the Ibex boot loader.
// The loader takes the slave side; the byte source / RAM model takes the master side.
interface ibex_boot_loader_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  localparam int BYTES = DATA_W / 8;

  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BYTES-1:0]  mem_be;

  modport master (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/ibex_boot_loader.sv
// Boot sequencer: loads a length-prefixed, checksummed word image from a byte stream into
// program RAM and releases the core reset RST_HOLD cycles after a good load or a bypass.
module ibex_boot_loader #(
  parameter int                ADDR_W    = 14,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
  parameter int                RST_HOLD  = 10,
  parameter logic [63:0]       MAX_WORDS = (64'd1 << ADDR_W) - 64'(BASE_ADDR)
) (
  input  logic              clk,
  input  logic              rst_n,
  ibex_boot_loader_if.slave bus,
  input  logic              bypass,
  output logic              core_rst_n,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int HC_W  = $clog2(RST_HOLD + 1);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_HOLD = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  state_e            state_r;
  logic [BC_W-1:0]   byte_cnt_r;
  logic [DATA_W-1:0] asm_r;
  logic [CNT_W-1:0]  num_words_r;
  logic [DATA_W-1:0] sum_r;
  logic [HC_W-1:0]   hold_cnt_r;
  logic              s_ready_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [BYTES-1:0]  mem_be_r;
  logic              core_rst_n_r;
  logic              done_r;
  logic              err_r;
  logic [CNT_W-1:0]  words_loaded_r;

  logic              accept_s;
  logic              last_byte_s;
  logic [DATA_W-1:0] word_s;
  logic [CNT_W-1:0]  next_loaded_s;
  logic              too_big_s;

  // Byte handshake and little-endian word assembly (new byte enters at the top, shifts down).
  always_comb begin
    accept_s      = bus.s_valid & s_ready_r;
    last_byte_s   = accept_s & (byte_cnt_r == LAST_BYTE);
    word_s        = (asm_r >> 8) | (DATA_W'(bus.s_data) << (DATA_W - 8));
    next_loaded_s = words_loaded_r + CNT_W'(1);
    too_big_s     = (64'(word_s) > MAX_WORDS);
  end

  // Boot FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= S_HDR;
      byte_cnt_r     <= '0;
      asm_r          <= '0;
      num_words_r    <= '0;
      sum_r          <= '0;
      hold_cnt_r     <= '0;
      s_ready_r      <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= BASE_ADDR;
      mem_wdata_r    <= '0;
      mem_be_r       <= '0;
      core_rst_n_r   <= 1'b0;
      done_r         <= 1'b0;
      err_r          <= 1'b0;
      words_loaded_r <= '0;
    end else begin
      mem_we_r <= 1'b0;
      mem_be_r <= '0;
      if (accept_s) begin
        asm_r      <= word_s;
        byte_cnt_r <= last_byte_s ? '0 : byte_cnt_r + BC_W'(1);
      end
      case (state_r)
        S_HDR: begin
          if (bypass) begin
            state_r    <= S_HOLD;
            s_ready_r  <= 1'b0;
            hold_cnt_r <= '0;
            byte_cnt_r <= '0;
          end else begin
            s_ready_r <= 1'b1;
            if (last_byte_s) begin
              if (too_big_s) begin
                state_r   <= S_ERR;
                err_r     <= 1'b1;
                s_ready_r <= 1'b0;
              end else if (word_s == '0) begin
                state_r <= S_CSUM;
              end else begin
                num_words_r <= CNT_W'(word_s);
                state_r     <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (last_byte_s) begin
            mem_we_r       <= 1'b1;
            mem_be_r       <= '1;
            mem_wdata_r    <= word_s;
            mem_addr_r     <= BASE_ADDR + ADDR_W'(words_loaded_r);
            words_loaded_r <= next_loaded_s;
            sum_r          <= sum_r + word_s;
            if (next_loaded_s == num_words_r) begin
              state_r <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (last_byte_s) begin
            s_ready_r <= 1'b0;
            if (word_s == sum_r) begin
              state_r    <= S_HOLD;
              hold_cnt_r <= '0;
            end else begin
              state_r <= S_ERR;
              err_r   <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          s_ready_r    <= 1'b0;
          core_rst_n_r <= 1'b0;
          // The release edge is the RST_HOLD-th edge after entering S_HOLD.
          if (hold_cnt_r == HOLD_LAST) begin
            state_r      <= S_RUN;
            core_rst_n_r <= 1'b1;
            done_r       <= 1'b1;
          end else begin
            hold_cnt_r <= hold_cnt_r + HC_W'(1);
          end
        end
        S_RUN: begin
          s_ready_r    <= 1'b0;
          core_rst_n_r <= 1'b1;
          done_r       <= 1'b1;
        end
        S_ERR: begin
          s_ready_r    <= 1'b0;
          core_rst_n_r <= 1'b0;
          err_r        <= 1'b1;
        end
        default: begin
          state_r      <= S_ERR;
          s_ready_r    <= 1'b0;
          core_rst_n_r <= 1'b0;
          err_r        <= 1'b1;
        end
      endcase
    end
  end

  assign bus.s_ready   = s_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_be    = mem_be_r;
  assign core_rst_n    = core_rst_n_r;
  assign done          = done_r;
  assign err           = err_r;
  assign words_loaded  = words_loaded_r;

endmodule

// File: tb/tb_ibex_boot_loader.sv
// Bench for ibex_boot_loader: two instances (BASE_ADDR 0 and 0x100); expected RAM writes are
// queued as words are sent and popped by per-instance write monitors.
module tb_ibex_boot_loader;
  localparam int AW   = 14;
  localparam int DW   = 32;
  localparam int HOLD = 10;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       bypass = 1'b0;
  logic       sv     = 1'b0;
  logic [7:0] sd     = 8'h00;
  int         sel    = 0;

  always #5 clk = ~clk;

  ibex_boot_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  ibex_boot_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  assign bus0.s_valid = sv && (sel == 0);
  assign bus0.s_data  = sd;
  assign bus1.s_valid = sv && (sel == 1);
  assign bus1.s_data  = sd;

  logic          core0, done0, err0, core1, done1, err1;
  logic [AW:0]   wl0, wl1;

  ibex_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .RST_HOLD(HOLD)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .bypass(bypass),
    .core_rst_n(core0), .done(done0), .err(err0), .words_loaded(wl0)
  );

  ibex_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(14'h100), .RST_HOLD(HOLD)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .bypass(bypass),
    .core_rst_n(core1), .done(done1), .err(err1), .words_loaded(wl1)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           q0[$];
  wr_t           q1[$];
  logic [DW-1:0] img[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor for instance 0.
  always @(negedge clk) begin
    wr_t e;
    if (bus0.mem_we) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wr0_unexpected: write addr 0x%0h data 0x%0h, expected none", bus0.mem_addr, bus0.mem_wdata);
      end else begin
        e = q0.pop_front();
        chk("wr0_addr", 64'(bus0.mem_addr), 64'(e.addr));
        chk("wr0_data", 64'(bus0.mem_wdata), 64'(e.data));
        chk("wr0_be", 64'(bus0.mem_be), 64'hF);
      end
    end
  end

  // Write monitor for instance 1.
  always @(negedge clk) begin
    wr_t e;
    if (bus1.mem_we) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wr1_unexpected: write addr 0x%0h data 0x%0h, expected none", bus1.mem_addr, bus1.mem_wdata);
      end else begin
        e = q1.pop_front();
        chk("wr1_addr", 64'(bus1.mem_addr), 64'(e.addr));
        chk("wr1_data", 64'(bus1.mem_wdata), 64'(e.data));
        chk("wr1_be", 64'(bus1.mem_be), 64'hF);
      end
    end
  end

  function automatic logic cur_ready();
    return (sel == 0) ? bus0.s_ready : bus1.s_ready;
  endfunction

  // Offer one byte; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int budget = 0;
    sv = 1'b1;
    sd = b;
    while (!cur_ready() && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!cur_ready()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: s_ready 0 for %0d cycles, expected 1", budget);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [DW-1:0] w, input bit gaps);
    for (int k = 0; k < DW / 8; k++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        sv = 1'b0;
        @(negedge clk);
      end
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic idle(input int n);
    sv = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Header, img words (stopping early if stop_at >= 0), then checksum.
  task automatic load(input logic [DW-1:0] n, input logic [DW-1:0] c, input bit gaps, input int stop_at);
    wr_t e;
    send_word(n, gaps);
    for (int i = 0; i < img.size(); i++) begin
      if (i == stop_at) begin
        sv = 1'b0;
        return;
      end
      e.addr = ((sel == 0) ? 14'h000 : 14'h100) + AW'(i);
      e.data = img[i];
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
      send_word(img[i], gaps);
    end
    send_word(c, gaps);
    sv = 1'b0;
  endtask

  task automatic do_reset(input logic byp);
    sv     = 1'b0;
    rst_n  = 1'b0;
    bypass = byp;
    repeat (2) @(negedge clk);
    chk("rst_core0", 64'(core0), 64'd0);
    chk("rst_done0", 64'(done0), 64'd0);
    chk("rst_err0", 64'(err0), 64'd0);
    chk("rst_wl0", 64'(wl0), 64'd0);
    chk("rst_ready0", 64'(bus0.s_ready), 64'd0);
    chk("rst_we0", 64'(bus0.mem_we), 64'd0);
    chk("rst_be0", 64'(bus0.mem_be), 64'd0);
    chk("rst_addr0", 64'(bus0.mem_addr), 64'h000);
    chk("rst_wdata0", 64'(bus0.mem_wdata), 64'd0);
    chk("rst_core1", 64'(core1), 64'd0);
    chk("rst_err1", 64'(err1), 64'd0);
    chk("rst_addr1", 64'(bus1.mem_addr), 64'h100);
    q0.delete();
    q1.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          seen_ready;
    logic [DW-1:0] sum;

    @(negedge clk);

    // 1: good 4-word load, release exactly HOLD edges after the last checksum byte.
    sel = 0;
    do_reset(1'b0);
    img = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    load(32'd4, 32'hAAAAAAAA, 1'b0, -1);
    idle(HOLD - 1);
    chk("t1_core_still_low", 64'(core0), 64'd0);
    idle(1);
    chk("t1_core_rise", 64'(core0), 64'd1);
    chk("t1_done", 64'(done0), 64'd1);
    chk("t1_err", 64'(err0), 64'd0);
    chk("t1_words", 64'(wl0), 64'd4);
    chk("t1_q_empty", 64'(q0.size()), 64'd0);

    // 2: bad checksum.
    do_reset(1'b0);
    load(32'd4, 32'hAAAAAAAB, 1'b0, -1);
    chk("t2_err", 64'(err0), 64'd1);
    chk("t2_ready", 64'(bus0.s_ready), 64'd0);
    idle(HOLD + 5);
    chk("t2_core", 64'(core0), 64'd0);
    chk("t2_done", 64'(done0), 64'd0);
    chk("t2_err_sticky", 64'(err0), 64'd1);
    chk("t2_ready_late", 64'(bus0.s_ready), 64'd0);

    // 3: oversize header on instance 0 (MAX_WORDS = 16384).
    do_reset(1'b0);
    img.delete();
    send_word(32'h00004001, 1'b0);
    sv = 1'b0;
    chk("t3_err", 64'(err0), 64'd1);
    chk("t3_ready", 64'(bus0.s_ready), 64'd0);
    idle(5);
    chk("t3_words", 64'(wl0), 64'd0);

    // Header boundaries on instance 1 (MAX_WORDS = 16128 = 0x3F00).
    sel = 1;
    do_reset(1'b0);
    send_word(32'h00003F00, 1'b0);
    sv = 1'b0;
    chk("max_ok_err", 64'(err1), 64'd0);
    chk("max_ok_ready", 64'(bus1.s_ready), 64'd1);
    do_reset(1'b0);
    send_word(32'h00003F01, 1'b0);
    sv = 1'b0;
    chk("max_p1_err", 64'(err1), 64'd1);

    // Empty image: N=0, checksum 0.
    sel = 0;
    do_reset(1'b0);
    load(32'd0, 32'd0, 1'b0, -1);
    idle(HOLD);
    chk("n0_core", 64'(core0), 64'd1);
    chk("n0_done", 64'(done0), 64'd1);
    chk("n0_words", 64'(wl0), 64'd0);

    // 4: bypass at reset release; bytes offered must never be taken.
    do_reset(1'b1);
    sv = 1'b1;
    sd = 8'hEE;
    seen_ready = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      seen_ready = seen_ready | bus0.s_ready;
    end
    chk("t4_core_low", 64'(core0), 64'd0);
    @(negedge clk);
    seen_ready = seen_ready | bus0.s_ready;
    chk("t4_core_rise", 64'(core0), 64'd1);
    chk("t4_done", 64'(done0), 64'd1);
    chk("t4_ready_never", 64'(seen_ready), 64'd0);
    chk("t4_words", 64'(wl0), 64'd0);
    sv = 1'b0;
    bypass = 1'b0;

    // 5: 16 words with random gaps on instance 1 (BASE_ADDR 0x100).
    sel = 1;
    do_reset(1'b0);
    img.delete();
    sum = 32'd0;
    for (int i = 0; i < 16; i++) begin
      img.push_back({8'(i), 8'(8'h5A ^ 8'(i)), 8'(~8'(i)), 8'hC3});
      sum = sum + img[i];
    end
    load(32'd16, sum, 1'b1, -1);
    idle(HOLD - 1);
    chk("t5_core_low", 64'(core1), 64'd0);
    idle(1);
    chk("t5_core", 64'(core1), 64'd1);
    chk("t5_done", 64'(done1), 64'd1);
    chk("t5_err", 64'(err1), 64'd0);
    chk("t5_words", 64'(wl1), 64'd16);
    chk("t5_q_empty", 64'(q1.size()), 64'd0);

    // 6: reset after word 2, then a fresh full load.
    sel = 0;
    do_reset(1'b0);
    img = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    load(32'd4, 32'hAAAAAAAA, 1'b0, 2);
    idle(2);
    chk("t6_words_mid", 64'(wl0), 64'd2);
    chk("t6_q_mid", 64'(q0.size()), 64'd0);
    do_reset(1'b0);
    load(32'd4, 32'hAAAAAAAA, 1'b0, -1);
    idle(HOLD);
    chk("t6_core", 64'(core0), 64'd1);
    chk("t6_done", 64'(done0), 64'd1);
    chk("t6_words", 64'(wl0), 64'd4);
    chk("t6_q_empty", 64'(q0.size()), 64'd0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
